// File: rtl/chronos_pkg.sv
// Shared tile-fabric types: tile count and the tile identifier used for routing.
package chronos_pkg;

    localparam int unsigned N_TILES   = 4;
    localparam int unsigned TILE_ID_W = 3;

    typedef logic [TILE_ID_W-1:0] tile_id_t;

endpackage

// File: rtl/tile_noc_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr;
// rr_ptr moves past the winner only when the grant is actually consumed.
module tile_noc_rr_arb #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] win_idx;
    logic          found;
    int unsigned   idx;

    // Scan requesters cyclically starting from the priority pointer.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(rr_ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_idx    = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (advance && found) begin
            rr_ptr <= (32'(win_idx) == N - 1) ? '0 : win_idx + PW'(1);
        end
    end

endmodule

// File: rtl/tile_xbar_noc.sv
// Tile crossbar: routes source flits to per-destination FIFOs with round-robin
// arbitration per destination; flits addressed past the last destination are dropped and counted.
module tile_xbar_noc
    import chronos_pkg::*;
#(
    parameter int unsigned NUM_SI     = N_TILES,
    parameter int unsigned NUM_MI     = N_TILES,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_DEPTH  = 4
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_SI-1:0]                   s_wvalid,
    output logic [NUM_SI-1:0]                   s_wready,
    input  logic [NUM_SI-1:0][DATA_WIDTH-1:0]   s_wdata,
    input  tile_id_t [NUM_SI-1:0]               s_port,
    output logic [NUM_MI-1:0]                   m_wvalid,
    input  logic [NUM_MI-1:0]                   m_wready,
    output logic [NUM_MI-1:0][DATA_WIDTH-1:0]   m_wdata,
    output logic [31:0]                         drop_count
);

    localparam int unsigned AW    = $clog2(OUT_DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tile_xbar_noc: OUT_DEPTH must be a power of two and at least 2");
    end
    if (NUM_MI > (2 ** $bits(tile_id_t))) begin : g_bad_mi
        $error("tile_xbar_noc: NUM_MI exceeds the tile_id_t address range");
    end

    logic [NUM_MI-1:0][NUM_SI-1:0] req;
    logic [NUM_MI-1:0][NUM_SI-1:0] grant;
    logic [NUM_MI-1:0]             full;
    logic [NUM_MI-1:0]             push;
    logic [NUM_SI-1:0]             oor;
    logic [32:0]                   drop_sum;

    // Request decode: each valid source requests exactly one destination or is out of range.
    always_comb begin
        req = '0;
        oor = '0;
        for (int unsigned i = 0; i < NUM_SI; i++) begin
            oor[i] = s_wvalid[i] && (32'(s_port[i]) >= NUM_MI);
            for (int unsigned j = 0; j < NUM_MI; j++) begin
                if (s_wvalid[i] && (32'(s_port[i]) == j)) begin
                    req[j][i] = 1'b1;
                end
            end
        end
    end

    // Ready depends only on grant and FIFO fullness, never on m_wready.
    always_comb begin
        s_wready = '0;
        if (rstn) begin
            for (int unsigned i = 0; i < NUM_SI; i++) begin
                s_wready[i] = oor[i];
                for (int unsigned j = 0; j < NUM_MI; j++) begin
                    if (grant[j][i] && !full[j]) begin
                        s_wready[i] = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_MI; j++) begin : g_dst
        logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
        logic [PTR_W-1:0]      wptr;
        logic [PTR_W-1:0]      rptr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  empty;
        logic                  pop;

        tile_noc_rr_arb #(
            .N (NUM_SI)
        ) u_arb (
            .clk     (clk),
            .rstn    (rstn),
            .req     (req[j]),
            .advance (push[j]),
            .grant   (grant[j])
        );

        assign full[j]     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        assign empty       = (wptr == rptr);
        assign push[j]     = (|grant[j]) && !full[j];
        assign m_wvalid[j] = rstn && !empty;
        assign pop         = m_wvalid[j] && m_wready[j];
        assign m_wdata[j]  = mem[rptr[AW-1:0]];

        always_comb begin
            wdata = '0;
            for (int unsigned i = 0; i < NUM_SI; i++) begin
                if (grant[j][i]) begin
                    wdata = s_wdata[i];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push[j]) begin
                mem[wptr[AW-1:0]] <= wdata;
            end
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push[j]) begin
                    wptr <= wptr + PTR_W'(1);
                end
                if (pop) begin
                    rptr <= rptr + PTR_W'(1);
                end
            end
        end
    end

    // Out-of-range flits are accepted and discarded; the count saturates.
    always_comb begin
        drop_sum = {1'b0, drop_count};
        for (int unsigned i = 0; i < NUM_SI; i++) begin
            if (oor[i]) begin
                drop_sum = drop_sum + 33'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            drop_count <= '0;
        end else begin
            drop_count <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
    end

endmodule

// File: tb/tb_tile_xbar_noc.sv
// Randomized bench for tile_xbar_noc against a queue-based reference model,
// plus a second instance with fewer destinations for the drop path.
module tb_tile_xbar_noc;
    import chronos_pkg::*;

    localparam int unsigned NSI   = 4;
    localparam int unsigned NMI   = 4;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [NSI-1:0]         s_wvalid = '0;
    logic [NSI-1:0]         s_wready;
    logic [NSI-1:0][31:0]   s_wdata = '0;
    tile_id_t [NSI-1:0]     s_port = '0;
    logic [NMI-1:0]         m_wvalid;
    logic [NMI-1:0]         m_wready = '0;
    logic [NMI-1:0][31:0]   m_wdata;
    logic [31:0]            drop_count;

    logic [NSI-1:0]         s3_wvalid = '0;
    logic [NSI-1:0]         s3_wready;
    logic [NSI-1:0][31:0]   s3_wdata = '0;
    tile_id_t [NSI-1:0]     s3_port = '0;
    logic [2:0]             m3_wvalid;
    logic [2:0]             m3_wready = '1;
    logic [2:0][31:0]       m3_wdata;
    logic [31:0]            drop3_count;

    tile_xbar_noc #(.NUM_SI(NSI), .NUM_MI(NMI), .DATA_WIDTH(32), .OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_port(s_port),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .drop_count(drop_count)
    );

    tile_xbar_noc #(.NUM_SI(NSI), .NUM_MI(3), .DATA_WIDTH(32), .OUT_DEPTH(DEPTH)) dut3 (
        .clk(clk), .rstn(rstn),
        .s_wvalid(s3_wvalid), .s_wready(s3_wready), .s_wdata(s3_wdata), .s_port(s3_port),
        .m_wvalid(m3_wvalid), .m_wready(m3_wready), .m_wdata(m3_wdata),
        .drop_count(drop3_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pending stimulus, applied on the next falling edge.
    logic                 p_rstn = 1'b1;
    logic [NSI-1:0]       p_valid = '0;
    tile_id_t [NSI-1:0]   p_port = '0;
    logic [NSI-1:0][31:0] p_data = '0;
    logic [NMI-1:0]       p_mready = '1;

    // Reference model state: queue contents, priority per destination, drop total.
    logic [31:0]    mq [NMI][$];
    int             rr [NMI];
    longint         drops = 0;
    logic [NSI-1:0] acc = '0;

    task automatic step();
        int             win [NMI];
        logic [NSI-1:0] exp_rdy;
        logic           ev;
        @(negedge clk);
        rstn     = p_rstn;
        s_wvalid = p_valid;
        s_port   = p_port;
        s_wdata  = p_data;
        m_wready = p_mready;
        #1;
        exp_rdy = '0;
        for (int j = 0; j < int'(NMI); j++) begin
            win[j] = -1;
            for (int k = 0; k < int'(NSI); k++) begin
                int i;
                i = (rr[j] + k) % int'(NSI);
                if (win[j] < 0 && p_valid[i] && int'(p_port[i]) == j) win[j] = i;
            end
            if (p_rstn && win[j] >= 0 && mq[j].size() < int'(DEPTH)) exp_rdy[win[j]] = 1'b1;
        end
        for (int i = 0; i < int'(NSI); i++) begin
            if (p_rstn && p_valid[i] && int'(p_port[i]) >= int'(NMI)) exp_rdy[i] = 1'b1;
            if (p_valid[i] || !p_rstn)
                check_eq($sformatf("s_wready[%0d]", i), 64'(s_wready[i]), 64'(exp_rdy[i]));
        end
        for (int j = 0; j < int'(NMI); j++) begin
            ev = p_rstn && (mq[j].size() > 0);
            check_eq($sformatf("m_wvalid[%0d]", j), 64'(m_wvalid[j]), 64'(ev));
            if (ev) check_eq($sformatf("m_wdata[%0d]", j), 64'(m_wdata[j]), 64'(mq[j][0]));
        end
        check_eq("drop_count", 64'(drop_count), 64'(drops));
        if (!p_rstn) begin
            for (int j = 0; j < int'(NMI); j++) begin
                mq[j].delete();
                rr[j] = 0;
            end
            drops = 0;
        end else begin
            for (int j = 0; j < int'(NMI); j++) begin
                if (mq[j].size() > 0 && p_mready[j]) void'(mq[j].pop_front());
                if (win[j] >= 0 && exp_rdy[win[j]]) begin
                    mq[j].push_back(p_data[win[j]]);
                    rr[j] = (win[j] + 1) % int'(NSI);
                end
            end
            for (int i = 0; i < int'(NSI); i++)
                if (p_valid[i] && int'(p_port[i]) >= int'(NMI)) drops++;
            if (drops > 64'hFFFF_FFFF) drops = 64'hFFFF_FFFF;
        end
        acc = exp_rdy & p_valid;
    endtask

    task automatic idle(input int n);
        p_valid  = '0;
        p_mready = '1;
        repeat (n) step();
    endtask

    int thr;

    initial begin
        for (int j = 0; j < int'(NMI); j++) rr[j] = 0;
        repeat (2) @(posedge clk);

        // Reset state
        p_rstn = 1'b0;
        p_valid = '1;
        step();
        p_rstn = 1'b1;
        idle(1);

        // Single flit to port 2
        p_valid = 4'b0001; p_port[0] = 3'd2; p_data[0] = 32'hA5; p_mready = '1;
        step();
        idle(2);

        // Four sources contend for port 1
        p_valid = '1;
        for (int i = 0; i < int'(NSI); i++) begin
            p_port[i] = 3'd1;
            p_data[i] = 32'h100 * 32'(i);
        end
        repeat (10) begin
            step();
            for (int i = 0; i < int'(NSI); i++) if (acc[i]) p_data[i] = p_data[i] + 32'd1;
        end
        idle(3);

        // Backpressure on port 3, then release
        p_valid = 4'b0100; p_port[2] = 3'd3; p_data[2] = 32'd1; p_mready = 4'b0111;
        for (int c = 0; c < 20; c++) begin
            if (c == 8) p_mready = '1;
            step();
            if (acc[2]) begin
                p_data[2] = p_data[2] + 32'd1;
                if (p_data[2] > 32'd6) p_valid[2] = 1'b0;
            end
        end
        idle(2);

        // Disjoint destinations in one cycle
        p_valid = '1;
        for (int i = 0; i < int'(NSI); i++) begin
            p_port[i] = tile_id_t'(3 - i);
            p_data[i] = 32'hC0 + 32'(i);
        end
        step();
        idle(2);

        // Out-of-range destinations
        p_valid = 4'b1010; p_port[1] = 3'd4; p_port[3] = 3'd7;
        step();
        step();
        idle(1);

        // Random traffic with varying backpressure
        for (int c = 0; c < 3000; c++) begin
            thr = 30 + 20 * ((c / 500) % 4);
            for (int j = 0; j < int'(NMI); j++) p_mready[j] = ($urandom_range(0, 99) < 32'(thr));
            for (int i = 0; i < int'(NSI); i++) begin
                if (!p_valid[i] || acc[i]) begin
                    p_valid[i] = ($urandom_range(0, 9) < 7);
                    p_port[i]  = ($urandom_range(0, 9) == 0) ? tile_id_t'(4 + $urandom_range(0, 3))
                                                             : tile_id_t'($urandom_range(0, 3));
                    p_data[i]  = $urandom;
                end else if ($urandom_range(0, 15) == 0) begin
                    p_valid[i] = 1'b0;
                end
            end
            step();
        end
        idle(8);

        // Mid-operation reset with FIFO 0 holding three flits
        p_mready = '0;
        p_valid = 4'b0001; p_port[0] = 3'd0;
        for (int k = 0; k < 3; k++) begin
            p_data[0] = 32'hD00 + 32'(k);
            step();
        end
        p_valid = '0;
        p_rstn = 1'b0;
        step();
        p_rstn = 1'b1;
        idle(4);

        // Three-destination instance: port 3 is out of range
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            s3_wvalid = 4'b0010; s3_port[1] = 3'd3; s3_wdata[1] = 32'hE0 + 32'(c);
            #1;
            check_eq("dut3 s_wready[1]", 64'(s3_wready[1]), 64'd1);
            check_eq("dut3 m_wvalid", 64'(m3_wvalid), 64'd0);
        end
        @(negedge clk);
        s3_wvalid = '0;
        #1;
        check_eq("dut3 drop_count", 64'(drop3_count), 64'd2);
        check_eq("dut3 m_wvalid idle", 64'(m3_wvalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
